// File: rtl/stack_pkg.sv
// stack_pkg: shared encodings and sizes for the stack arbiter and its stack
package stack_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;
  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP = 1'b0;
  localparam int STACK_DATA_W = 16;
  localparam int STACK_DEPTH = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  logic [IW-1:0] w_j;
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_j]) begin
        o_idx = w_j;
        o_any = 1'b1;
      end
    end
    o_grant = o_any ? NREQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one hardware stack among NREQ requesters
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DATA_W = STACK_DATA_W,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_op,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic [ADDR_WIDTH-1:0]  level,
  output logic                   stk_enable,
  output logic                   stk_op,
  output logic [DATA_W-1:0]      stk_din,
  input  logic [DATA_W-1:0]      stk_dout,
  input  logic                   stk_full,
  input  logic                   stk_empty
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t r_state;
  logic [IW-1:0] r_ptr, r_id, w_idx;
  logic r_lock, r_op, r_err, w_any, w_illegal;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_level;
  logic [NREQ-1:0] w_mask, w_grant;
  // r_id doubles as the lock owner: while locked only the owner can be accepted
  assign w_mask = r_lock ? req_valid & (NREQ'(1) << r_id) : req_valid;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .i_req(w_mask), .i_ptr(r_ptr), .o_grant(w_grant), .o_idx(w_idx), .o_any(w_any)
  );
  assign w_illegal = (r_op == OP_PUSH) ? stk_full : stk_empty;
  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign rsp_valid = (r_state == ST_RESP) ? NREQ'(1) << r_id : '0;
  assign rsp_data = (r_state == ST_RESP && !r_err && r_op == OP_POP) ? stk_dout : '0;
  assign rsp_err = (r_state == ST_RESP) && r_err;
  assign level = r_level;
  assign stk_enable = (r_state == ST_ISSUE) && !w_illegal;
  assign stk_op = stk_enable && r_op;
  assign stk_din = stk_enable ? r_data : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr <= '0;
      r_id <= '0;
      r_lock <= 1'b0;
      r_op <= 1'b0;
      r_err <= 1'b0;
      r_data <= '0;
      r_level <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_state <= ST_ISSUE;
          r_op <= req_op[w_idx];
          r_data <= req_data[w_idx*DATA_W +: DATA_W];
          r_lock <= req_lock[w_idx];
          r_id <= w_idx;
          r_ptr <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
        end
        ST_ISSUE: begin
          r_state <= ST_RESP;
          r_err <= w_illegal;
          if (!w_illegal) r_level <= (r_op == OP_PUSH) ? r_level + 1'b1 : r_level - 1'b1;
        end
        ST_RESP: if (rsp_ready[r_id]) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
